// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
//   Shared types and defaults for the exec sequencer. It holds the per-channel
//   state encoding and the default synchroniser depth and hold length.
//   It has no ports.
// ----------------------------------------------------------------------------
package exec_pkg;

  // Per-channel control state. The encoding is fixed so that debug probes
  // decode the same way on every build.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    RUN    = 2'd2
  } exec_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_HOLD_CYCLES = 5;

endpackage : exec_pkg

// File: rtl/exec_sequencer_if.sv
// ----------------------------------------------------------------------------
// exec_sequencer_if
//   Bundle between the board exec inputs and the core reset/run controls.
//   Ports (signals):
//     exec        board -> sequencer   asynchronous exec levels, one per channel
//     exec_sig    sequencer -> core    synchronised exec level
//     exec_reset  sequencer -> core    per-channel core reset
//     exec_run    sequencer -> core    channel is running
//     exec_start  sequencer -> core    one-cycle pulse on entering RUN
//     exec_stop   sequencer -> core    one-cycle pulse on leaving RUN
//     any_reset   sequencer -> core    OR of all exec_reset bits
//   Modports:
//     master  drives exec and observes the controls (board side)
//     slave   the sequencer itself
//   NUM_CH must match the NUM_CH of the exec_sequencer it connects to.
// ----------------------------------------------------------------------------
interface exec_sequencer_if #(
  parameter int NUM_CH = 1
);

  logic [NUM_CH-1:0] exec;
  logic [NUM_CH-1:0] exec_sig;
  logic [NUM_CH-1:0] exec_reset;
  logic [NUM_CH-1:0] exec_run;
  logic [NUM_CH-1:0] exec_start;
  logic [NUM_CH-1:0] exec_stop;
  logic              any_reset;

  modport master (
    output exec,
    input  exec_sig, exec_reset, exec_run, exec_start, exec_stop, any_reset
  );

  modport slave (
    input  exec,
    output exec_sig, exec_reset, exec_run, exec_start, exec_stop, any_reset
  );

endinterface : exec_sequencer_if

// File: rtl/exec_channel.sv
// ----------------------------------------------------------------------------
// exec_channel
//   One independent exec channel. It synchronises the asynchronous exec level
//   and detects its rising edge. It then holds the core reset until the level
//   has been high for HOLD_CYCLES consecutive cycles. After that it runs until
//   the level drops.
//   Ports:
//     clock       system clock, rising edge
//     reset       synchronous, active-high
//     exec        asynchronous exec level
//     exec_sig    synchronised exec level (last synchroniser stage)
//     exec_reset  registered core reset
//     exec_run    high while in RUN
//     exec_start  one-cycle pulse on ASSERT -> RUN
//     exec_stop   one-cycle pulse on RUN -> IDLE
//     reset_next  value exec_reset takes at the next edge. It lets the parent
//                 register an OR that stays cycle-aligned with exec_reset.
// ----------------------------------------------------------------------------
module exec_channel
  import exec_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
  parameter bit LOW_ABORT   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic exec,
  output logic exec_sig,
  output logic exec_reset,
  output logic exec_run,
  output logic exec_start,
  output logic exec_stop,
  output logic reset_next
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_prev;
  logic                   rise;
  exec_state_t            state;
  logic [CNT_W-1:0]       cnt;

  assign s        = sync[SYNC_STAGES-1];
  assign exec_sig = s;
  assign rise     = s & ~s_prev;

  // The synchroniser is cleared on reset. A level that is already high when
  // reset releases therefore shows up as a fresh rising edge.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the sync chain.
    if (reset) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], exec};
      s_prev <= s;
    end
  end

  // Control FSM with registered outputs. Pulses default low every cycle and
  // are raised only on their transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      exec_reset <= 1'b0;
      exec_run   <= 1'b0;
      exec_start <= 1'b0;
      exec_stop  <= 1'b0;
    end else begin
      exec_start <= 1'b0;
      exec_stop  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state      <= ASSERT;
            exec_reset <= 1'b1;
            cnt        <= CNT_W'(1);
          end
        end
        ASSERT: begin
          if (s) begin
            if (cnt == HOLD_MAX) begin
              state      <= RUN;
              exec_reset <= 1'b0;
              exec_run   <= 1'b1;
              exec_start <= 1'b1;
              cnt        <= '0;
            end else begin
              // cnt only climbs toward HOLD_MAX here, so it saturates there.
              cnt <= cnt + 1'b1;
            end
          end else if (LOW_ABORT) begin
            state      <= IDLE;
            exec_reset <= 1'b0;
            cnt        <= '0;
          end else begin
            // A dropout restarts the hold and keeps the core in reset.
            cnt <= '0;
          end
        end
        RUN: begin
          if (!s) begin
            state     <= IDLE;
            exec_run  <= 1'b0;
            exec_stop <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          exec_reset <= 1'b0;
          exec_run   <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

  // This mirrors the exec_reset decisions above, without the reset override.
  // The parent's any_reset register applies that override itself.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    reset_next = 1'b0;
    case (state)
      IDLE:    reset_next = rise;
      ASSERT:  reset_next = s ? (cnt != HOLD_MAX) : !LOW_ABORT;
      RUN:     reset_next = 1'b0;
      default: reset_next = 1'b0;
    endcase
  end

endmodule : exec_channel

// File: rtl/exec_sequencer.sv
// ----------------------------------------------------------------------------
// exec_sequencer
//   Multi-channel exec control between board I/O and the core reset/run
//   controls. It holds NUM_CH independent exec_channel instances and the
//   registered any_reset OR.
//   Ports:
//     clock  system clock, rising edge
//     reset  synchronous, active-high
//     bus    exec_sequencer_if.slave (exec in; exec_sig, exec_reset,
//            exec_run, exec_start, exec_stop, any_reset out)
// ----------------------------------------------------------------------------
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int NUM_CH      = 1,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
  parameter bit LOW_ABORT   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  exec_sequencer_if.slave   bus
);

  logic [NUM_CH-1:0] reset_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    exec_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W),
      .LOW_ABORT   (LOW_ABORT)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .exec       (bus.exec[i]),
      .exec_sig   (bus.exec_sig[i]),
      .exec_reset (bus.exec_reset[i]),
      .exec_run   (bus.exec_run[i]),
      .exec_start (bus.exec_start[i]),
      .exec_stop  (bus.exec_stop[i]),
      .reset_next (reset_next[i])
    );
  end

  // The register is built from next-state values. This keeps it on the same
  // cycle as the exec_reset flops instead of one cycle behind them.
  always_ff @(posedge clock) begin
    if (reset) bus.any_reset <= 1'b0;
    else       bus.any_reset <= |reset_next;
  end

endmodule : exec_sequencer
